// File: rtl/fetch_pkg.sv
// Shared constants and state/select encodings for the fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INCR   = 32'd4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_STEP = 2'd1,
    PC_JUMP = 2'd2
  } pc_sel_t;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC selection: hold, sequential step, or word-aligned redirect.
module pc_next
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic [ADDRESS_WIDTH-1:0] pc,
  input  logic [ADDRESS_WIDTH-1:0] target,
  input  logic [1:0]               sel,
  output logic [ADDRESS_WIDTH-1:0] next_pc
);

  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~ADDRESS_WIDTH'(2'b11);

  // Next-PC mux; the step wraps naturally at the top of the address space.
  always_comb begin
    next_pc = pc;
    case (sel)
      PC_HOLD: next_pc = pc;
      PC_STEP: next_pc = pc + ADDRESS_WIDTH'(PC_INCR);
      PC_JUMP: next_pc = target & ALIGN_MASK;
      default: next_pc = pc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// PC sequencing and IF/ID fetch register for the reduced RISC-V core.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH = 32,
  parameter int                     DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] target,
  output logic [ADDRESS_WIDTH-1:0] instr_addr,
  input  logic [DATA_WIDTH-1:0]    instr_rdata,
  output logic [DATA_WIDTH-1:0]    if_instr,
  output logic [ADDRESS_WIDTH-1:0] if_pc,
  output logic                     if_valid,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic                     misalign,
`endif
  output logic                     halted
);

  fetch_state_t             state_r, state_nxt_s;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_nxt_s;
  logic [1:0]               pc_sel_s;
  logic [DATA_WIDTH-1:0]    if_instr_nxt_s;
  logic [ADDRESS_WIDTH-1:0] if_pc_nxt_s;
  logic                     if_valid_nxt_s;
  logic                     halted_nxt_s;
  logic                     bad_target_s;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic                     misalign_nxt_s;
  assign bad_target_s = |target[1:0];
`else
  assign bad_target_s = 1'b0;
`endif

  assign instr_addr = pc_q;

  pc_next #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_pc_next (
    .pc      (pc_q),
    .target  (target),
    .sel     (pc_sel_s),
    .next_pc (pc_nxt_s)
  );

  // Next-state and fetch-register update decisions.
  always_comb begin
    state_nxt_s    = state_r;
    pc_sel_s       = PC_HOLD;
    if_instr_nxt_s = if_instr;
    if_pc_nxt_s    = if_pc;
    if_valid_nxt_s = if_valid;
    halted_nxt_s   = halted;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_nxt_s = misalign;
`endif
    case (state_r)
      BOOT: begin
        state_nxt_s = RUN;
      end
      RUN: begin
        if (redirect) begin
          if (bad_target_s) begin
            state_nxt_s    = HALT;
            halted_nxt_s   = 1'b1;
            if_valid_nxt_s = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_nxt_s = 1'b1;
`endif
          end else begin
            pc_sel_s       = PC_JUMP;
            if_valid_nxt_s = 1'b0;
            if_instr_nxt_s = DATA_WIDTH'(NOP_INSTR);
          end
        end else if (stall) begin
          pc_sel_s = PC_HOLD;
        end else if (instr_rdata == '0) begin
          state_nxt_s    = HALT;
          halted_nxt_s   = 1'b1;
          if_valid_nxt_s = 1'b0;
        end else begin
          pc_sel_s       = PC_STEP;
          if_instr_nxt_s = instr_rdata;
          if_pc_nxt_s    = pc_q;
          if_valid_nxt_s = 1'b1;
        end
      end
      HALT: begin
        if_valid_nxt_s = 1'b0;
        halted_nxt_s   = 1'b1;
        if (redirect && !bad_target_s) begin
          state_nxt_s    = RUN;
          pc_sel_s       = PC_JUMP;
          halted_nxt_s   = 1'b0;
          if_instr_nxt_s = DATA_WIDTH'(NOP_INSTR);
        end else if (redirect) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          misalign_nxt_s = 1'b1;
`endif
          state_nxt_s = HALT;
        end else begin
          state_nxt_s = HALT;
        end
      end
      default: begin
        state_nxt_s = BOOT;
      end
    endcase
  end

  // State, PC and fetch register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= BOOT;
      pc_q     <= RESET_PC;
      if_instr <= DATA_WIDTH'(NOP_INSTR);
      if_pc    <= '0;
      if_valid <= 1'b0;
      halted   <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign <= 1'b0;
`endif
    end else begin
      state_r  <= state_nxt_s;
      pc_q     <= pc_nxt_s;
      if_instr <= if_instr_nxt_s;
      if_pc    <= if_pc_nxt_s;
      if_valid <= if_valid_nxt_s;
      halted   <= halted_nxt_s;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign <= misalign_nxt_s;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a small behavioural ROM.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] instr_addr;
  logic [31:0] instr_rdata;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        halted;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  logic [31:0] mem [0:63];
  int          n_chk  = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  // Low 256 bytes come from mem; the top 256 bytes read as NOP; everything else is zero.
  assign instr_rdata = (instr_addr[31:8] == 24'h0) ? mem[instr_addr[7:2]] :
                       ((instr_addr[31:8] == 24'hFF_FFFF) ? 32'h0000_0013 : 32'h0000_0000);

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .target      (target),
    .instr_addr  (instr_addr),
    .instr_rdata (instr_rdata),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_valid    (if_valid),
`ifdef FETCH_MISALIGN_TRAP_EN
    .misalign    (misalign),
`endif
    .halted      (halted)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; target = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0]  = 32'h0050_0093;
    mem[1]  = 32'h0010_0113;
    mem[3]  = 32'h0070_0413;
    mem[4]  = 32'h0080_0493;
    mem[8]  = 32'h0030_0213;
    mem[16] = 32'h0040_0293;
    mem[17] = 32'h0050_0313;
    tick(); tick();
    check_eq("rst_addr", instr_addr, 32'h0);
    check_eq("rst_instr", if_instr, 32'h0000_0013);
    check_eq("rst_pc", if_pc, 32'h0);
    check_eq("rst_valid", {31'h0, if_valid}, 32'h0);
    check_eq("rst_halted", {31'h0, halted}, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check_eq("rst_misalign", {31'h0, misalign}, 32'h0);
`endif

    rst_n = 1'b1;
    tick();
    check_eq("boot_valid", {31'h0, if_valid}, 32'h0);
    check_eq("boot_addr", instr_addr, 32'h0);
    tick();
    check_eq("f0_valid", {31'h0, if_valid}, 32'h1);
    check_eq("f0_pc", if_pc, 32'h0);
    check_eq("f0_instr", if_instr, 32'h0050_0093);
    check_eq("f0_addr", instr_addr, 32'h4);
    tick();
    check_eq("f1_pc", if_pc, 32'h4);
    check_eq("f1_instr", if_instr, 32'h0010_0113);
    tick();
    check_eq("h0_halted", {31'h0, halted}, 32'h1);
    check_eq("h0_valid", {31'h0, if_valid}, 32'h0);
    check_eq("h0_addr", instr_addr, 32'h8);
    tick();
    check_eq("h0_hold_addr", instr_addr, 32'h8);

    // Leave HALT back to 0 (stall has no effect there), then stall at pc 4.
    redirect = 1'b1; stall = 1'b1; target = 32'h0;
    tick();
    check_eq("hx_halted", {31'h0, halted}, 32'h0);
    check_eq("hx_addr", instr_addr, 32'h0);
    redirect = 1'b0; stall = 1'b0;
    tick();
    check_eq("s_pre_addr", instr_addr, 32'h4);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_addr", instr_addr, 32'h4);
      check_eq("stall_pc", if_pc, 32'h0);
      check_eq("stall_instr", if_instr, 32'h0050_0093);
      check_eq("stall_valid", {31'h0, if_valid}, 32'h1);
    end
    stall = 1'b0;
    tick();
    check_eq("resume_pc", if_pc, 32'h4);
    check_eq("resume_addr", instr_addr, 32'h8);

    // Redirect wins over a simultaneous stall; one bubble.
    redirect = 1'b1; stall = 1'b1; target = 32'h20;
    tick();
    check_eq("rd_addr", instr_addr, 32'h20);
    check_eq("rd_valid", {31'h0, if_valid}, 32'h0);
    check_eq("rd_instr", if_instr, 32'h0000_0013);
    check_eq("rd_pc_keep", if_pc, 32'h4);
    redirect = 1'b0; stall = 1'b0;
    tick();
    check_eq("rd1_pc", if_pc, 32'h20);
    check_eq("rd1_valid", {31'h0, if_valid}, 32'h1);
    check_eq("rd1_instr", if_instr, 32'h0030_0213);
    tick();
    check_eq("h1_halted", {31'h0, halted}, 32'h1);
    check_eq("h1_addr", instr_addr, 32'h24);

    redirect = 1'b1; target = 32'h40;
    tick();
    check_eq("hr_halted", {31'h0, halted}, 32'h0);
    check_eq("hr_addr", instr_addr, 32'h40);
    redirect = 1'b0;
    tick();
    check_eq("hr_pc", if_pc, 32'h40);
    check_eq("hr_valid", {31'h0, if_valid}, 32'h1);
    check_eq("hr_next", instr_addr, 32'h44);

    redirect = 1'b1; target = 32'h22;
    tick();
`ifdef FETCH_MISALIGN_TRAP_EN
    check_eq("mis_flag", {31'h0, misalign}, 32'h1);
    check_eq("mis_halted", {31'h0, halted}, 32'h1);
    check_eq("mis_addr", instr_addr, 32'h44);
`else
    check_eq("mis_addr", instr_addr, 32'h20);
    check_eq("mis_halted", {31'h0, halted}, 32'h0);
`endif
    check_eq("mis_valid", {31'h0, if_valid}, 32'h0);

    // Increment wraps at the top of the address space.
    target = 32'hFFFF_FFFC;
    tick();
    check_eq("wr_addr", instr_addr, 32'hFFFF_FFFC);
    redirect = 1'b0;
    tick();
    check_eq("wrap_addr", instr_addr, 32'h0);
    check_eq("wrap_pc", if_pc, 32'hFFFF_FFFC);
    check_eq("wrap_valid", {31'h0, if_valid}, 32'h1);

    redirect = 1'b1; target = 32'hC;
    tick();
    redirect = 1'b0;
    tick();
    check_eq("pre_rst_addr", instr_addr, 32'h10);
    rst_n = 1'b0;
    #1;
    check_eq("arst_addr", instr_addr, 32'h0);
    check_eq("arst_valid", {31'h0, if_valid}, 32'h0);
    check_eq("arst_halted", {31'h0, halted}, 32'h0);
    check_eq("arst_instr", if_instr, 32'h0000_0013);
    tick();
    rst_n = 1'b1; redirect = 1'b1; target = 32'h40;
    tick();
    check_eq("boot2_addr", instr_addr, 32'h0);
    check_eq("boot2_valid", {31'h0, if_valid}, 32'h0);
    redirect = 1'b0;
    tick();
    check_eq("boot2_f_valid", {31'h0, if_valid}, 32'h1);
    check_eq("boot2_f_pc", if_pc, 32'h0);
    check_eq("boot2_f_addr", instr_addr, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
